// File: rtl/pri_enc_drain_pkg.sv
// Shared types and helpers for the request-drain priority encoder.
package pri_enc_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } pri_drain_state_e;

   // Index width that never collapses to zero bits for tiny vectors.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pri_enc_drain_sel.sv
// Combinational priority select: winning index, its one-hot mask,
// and whether any / exactly one request bit is set.
module pri_sel
   import pri_enc_pkg::*;
#(
   parameter int unsigned N         = 8,
   parameter bit          MSB_FIRST = 1'b1,
   localparam int unsigned IDX_W    = idx_width(N)
) (
   input  logic [N-1:0]     rem,
   output logic [IDX_W-1:0] idx,
   output logic [N-1:0]     mask,
   output logic             any,
   output logic             single
);

   // Last match in scan order wins, so scan toward the priority end.
   always_comb begin
      idx = '0;
      if (MSB_FIRST) begin
         for (int i = 0; i < int'(N); i++)
            if (rem[i]) idx = IDX_W'(i);
      end else begin
         for (int i = int'(N) - 1; i >= 0; i--)
            if (rem[i]) idx = IDX_W'(i);
      end
      any    = |rem;
      mask   = any ? (N'(1) << idx) : '0;
      single = any & ~(|(rem & (rem - N'(1))));
   end

endmodule

// File: rtl/pri_enc_drain.sv
// Registered priority encoder: captures a request vector and drains the
// index of every set bit, one per accepted beat, in priority order.
// Optional macro PRI_ENC_DRAIN_COUNT_EN adds out_cnt (remaining popcount).
module pri_enc_drain
   import pri_enc_pkg::*;
#(
   parameter int unsigned N         = 8,
   parameter bit          MSB_FIRST = 1'b1,
   localparam int unsigned IDX_W    = idx_width(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_vec,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_none,
   output logic             out_last,
   output logic             busy
`ifdef PRI_ENC_DRAIN_COUNT_EN
   ,
   output logic [IDX_W:0]   out_cnt
`endif
);

   pri_drain_state_e state, state_nxt;
   logic [N-1:0]     rem;
   logic             zflag;

   logic [IDX_W-1:0] sel_idx;
   logic [N-1:0]     sel_mask;
   logic             sel_any;
   logic             sel_single;
   logic             last_c;
   logic             accept;
   logic             fire;

   pri_sel #(
      .N         (N),
      .MSB_FIRST (MSB_FIRST)
   ) u_sel (
      .rem    (rem),
      .idx    (sel_idx),
      .mask   (sel_mask),
      .any    (sel_any),
      .single (sel_single)
   );

   // Final beat: zero vector, one bit left, or (defensively) nothing left.
   assign last_c = zflag | sel_single | ~sel_any;
   assign accept = (state == IDLE) & in_valid;
   assign fire   = (state == DRAIN) & out_ready;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state: capture in IDLE, return after the last accepted beat.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = DRAIN;
         DRAIN:   if (out_ready && last_c) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from registered state, rem and zflag only.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_idx   = '0;
      out_none  = 1'b0;
      out_last  = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: in_ready = 1'b1;
         DRAIN: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            out_idx   = sel_idx;
            out_none  = zflag;
            out_last  = last_c;
         end
         default: in_ready = 1'b1;
      endcase
   end

   // Remaining-bit vector and zero-vector flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem   <= '0;
         zflag <= 1'b0;
      end else if (accept) begin
         rem   <= in_vec;
         zflag <= (in_vec == '0);
      end else if (fire) begin
         rem <= rem & ~sel_mask;
         if (last_c) zflag <= 1'b0;
      end
   end

`ifdef PRI_ENC_DRAIN_COUNT_EN
   localparam int unsigned CNT_W = IDX_W + 1;

   // Remaining request count while draining.
   always_comb begin
      out_cnt = '0;
      if (state == DRAIN)
         for (int i = 0; i < int'(N); i++)
            out_cnt = out_cnt + CNT_W'(rem[i]);
   end
`endif

endmodule

// File: tb/tb_pri_enc_drain.sv
// Bench for pri_enc_drain: MSB-first and LSB-first instances share stimulus;
// a beat-list model predicts every output on every cycle.
module tb_pri_enc_drain;

   typedef struct packed {
      logic [2:0] idx;
      logic       none;
      logic       last;
      logic [3:0] cnt;
   } beat_t;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_vec;
   logic       out_ready;

   logic       in_ready_m, out_valid_m, out_none_m, out_last_m, busy_m;
   logic [2:0] out_idx_m;
   logic       in_ready_l, out_valid_l, out_none_l, out_last_l, busy_l;
   logic [2:0] out_idx_l;
`ifdef PRI_ENC_DRAIN_COUNT_EN
   logic [3:0] cnt_m, cnt_l;
`endif

   int    checks;
   int    errors;
   beat_t qm[$];
   beat_t ql[$];

   pri_enc_drain #(.N(8), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m),
      .in_vec(in_vec), .out_valid(out_valid_m), .out_ready(out_ready),
      .out_idx(out_idx_m), .out_none(out_none_m), .out_last(out_last_m),
      .busy(busy_m)
`ifdef PRI_ENC_DRAIN_COUNT_EN
      , .out_cnt(cnt_m)
`endif
   );

   pri_enc_drain #(.N(8), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l),
      .in_vec(in_vec), .out_valid(out_valid_l), .out_ready(out_ready),
      .out_idx(out_idx_l), .out_none(out_none_l), .out_last(out_last_l),
      .busy(busy_l)
`ifdef PRI_ENC_DRAIN_COUNT_EN
      , .out_cnt(cnt_l)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Expand a captured vector into its ordered list of beats.
   function automatic void push_vec(input logic [7:0] v);
      int    k;
      int    pos;
      beat_t b;
      k = $countones(v);
      if (v == 8'h00) begin
         b = '{idx: 3'd0, none: 1'b1, last: 1'b1, cnt: 4'd0};
         qm.push_back(b);
         ql.push_back(b);
      end else begin
         pos = 0;
         for (int i = 7; i >= 0; i--)
            if (v[i]) begin
               b = '{idx: 3'(i), none: 1'b0, last: (pos == k - 1), cnt: 4'(k - pos)};
               qm.push_back(b);
               pos++;
            end
         pos = 0;
         for (int i = 0; i < 8; i++)
            if (v[i]) begin
               b = '{idx: 3'(i), none: 1'b0, last: (pos == k - 1), cnt: 4'(k - pos)};
               ql.push_back(b);
               pos++;
            end
      end
   endfunction

   task automatic check_dut(input string tag, input bit has, input beat_t b,
                            input logic ir, input logic ov, input logic [2:0] idx,
                            input logic nn, input logic lst, input logic bsy,
                            input logic [3:0] cnt);
      chk({tag, ".in_ready"},  32'(ir),  has ? 0 : 1);
      chk({tag, ".out_valid"}, 32'(ov),  has ? 1 : 0);
      chk({tag, ".out_idx"},   32'(idx), 32'(b.idx));
      chk({tag, ".out_none"},  32'(nn),  32'(b.none));
      chk({tag, ".out_last"},  32'(lst), 32'(b.last));
      chk({tag, ".busy"},      32'(bsy), has ? 1 : 0);
`ifdef PRI_ENC_DRAIN_COUNT_EN
      chk({tag, ".out_cnt"},   32'(cnt), 32'(b.cnt));
`else
      if (cnt != 4'd0) chk({tag, ".cnt_tie"}, 32'(cnt), 0);
`endif
   endtask

   task automatic check_all();
      beat_t bm, bl;
      logic [3:0] cm, cl;
      bit has;
      has = (qm.size() != 0);
      bm  = has ? qm[0] : '0;
      bl  = has ? ql[0] : '0;
`ifdef PRI_ENC_DRAIN_COUNT_EN
      cm = cnt_m;
      cl = cnt_l;
`else
      cm = 4'd0;
      cl = 4'd0;
`endif
      check_dut("msb", has, bm, in_ready_m, out_valid_m, out_idx_m,
                out_none_m, out_last_m, busy_m, cm);
      check_dut("lsb", has, bl, in_ready_l, out_valid_l, out_idx_l,
                out_none_l, out_last_l, busy_l, cl);
   endtask

   // One clock: advance the model on the edge, compare just after it.
   task automatic tick();
      @(posedge clk);
      if (!rst) begin
         if (qm.size() == 0) begin
            if (in_valid) push_vec(in_vec);
         end else if (out_ready) begin
            void'(qm.pop_front());
            void'(ql.pop_front());
         end
      end
      #1;
      check_all();
   endtask

   task automatic send(input logic [7:0] v);
      in_valid = 1'b1;
      in_vec   = v;
      tick();
      in_valid = 1'b0;
      in_vec   = 8'h00;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_vec    = 8'h00;
      out_ready = 1'b1;
      #2;
      check_all();
      chk("rst.in_ready", 32'(in_ready_m), 1);
      chk("rst.out_valid", 32'(out_valid_m), 0);
      rst = 1'b0;

      // 1010_0101 at full throughput
      send(8'hA5);
      chk("a5.first_msb", 32'(out_idx_m), 7);
      chk("a5.first_lsb", 32'(out_idx_l), 0);
      tick();
      chk("a5.second_msb", 32'(out_idx_m), 5);
      chk("a5.second_lsb", 32'(out_idx_l), 2);
      tick();
      tick();
      chk("a5.last_msb_idx", 32'(out_idx_m), 0);
      chk("a5.last_msb_flag", 32'(out_last_m), 1);
      chk("a5.last_lsb_idx", 32'(out_idx_l), 7);
      tick();
      chk("a5.bubble_ready", 32'(in_ready_m), 1);

      // zero vector
      send(8'h00);
      chk("zero.none", 32'(out_none_m), 1);
      chk("zero.last", 32'(out_last_m), 1);
      chk("zero.idx", 32'(out_idx_m), 0);
      tick();
      chk("zero.idle", 32'(busy_m), 0);

      // backpressure on 1000_0001
      out_ready = 1'b0;
      send(8'h81);
      for (int i = 0; i < 5; i++) tick();
      chk("bp.hold_idx", 32'(out_idx_m), 7);
      chk("bp.hold_valid", 32'(out_valid_m), 1);
      out_ready = 1'b1;
      tick();
      chk("bp.second_idx", 32'(out_idx_m), 0);
      tick();
      tick();

      // async reset mid-drain
      send(8'hFF);
      tick();
      tick();
      tick();
      chk("ff.after3_msb", 32'(out_idx_m), 4);
      chk("ff.after3_lsb", 32'(out_idx_l), 3);
      #3;
      rst = 1'b1;
      qm.delete();
      ql.delete();
      #1;
      check_all();
      chk("arst.out_valid", 32'(out_valid_m), 0);
      chk("arst.in_ready", 32'(in_ready_l), 1);
      #2;
      rst = 1'b0;
      send(8'h10);
      chk("post.idx_msb", 32'(out_idx_m), 4);
      chk("post.idx_lsb", 32'(out_idx_l), 4);
      chk("post.last", 32'(out_last_m), 1);
      tick();
      chk("post.idle", 32'(out_valid_m), 0);

      // 0000_1011 with remaining-count view
      send(8'h0B);
      chk("0b.idx", 32'(out_idx_m), 3);
`ifdef PRI_ENC_DRAIN_COUNT_EN
      chk("0b.cnt3", 32'(cnt_m), 3);
`endif
      tick();
`ifdef PRI_ENC_DRAIN_COUNT_EN
      chk("0b.cnt2", 32'(cnt_m), 2);
`endif
      tick();
      tick();
`ifdef PRI_ENC_DRAIN_COUNT_EN
      chk("0b.cnt_idle", 32'(cnt_m), 0);
`endif

      // in_valid held high across drains: new vectors only taken in IDLE
      in_valid = 1'b1;
      in_vec   = 8'h06;
      tick();
      in_vec   = 8'hF0;
      tick();
      tick();
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++) tick();

      // mixed traffic
      for (int i = 0; i < 200; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_vec    = 8'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      chk("end.idle", 32'(in_ready_m), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
